// File: rtl/audio_pll_supervisor.sv
// Lock supervisor and reset sequencer for the audio PLL.
// It pulses the PLL reset, qualifies lock with a timeout and retries, then releases the two audio domains in order.
module audio_pll_supervisor #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int RELEASE_GAP_CYC  = 64,
    parameter int MAX_ATTEMPTS     = 3,
    parameter int CNT_W            = 20
) (
    input  logic       refclk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    input  logic       restart_req_i,
    output logic       pll_rst_o,
    output logic [1:0] dom_rst_o,
    output logic       lock_ok_o,
    output logic       fail_o,
    output logic       lock_lost_o,
    output logic [1:0] attempt_cnt_o,
    output logic [7:0] lost_cnt_o
);

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_RELEASE   = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAIL      = 3'd4;

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(RELEASE_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic             lockedMeta_q;
    logic             lockedSync_q;
    logic [2:0]       state_q,   state_d;
    logic [CNT_W-1:0] phase_q,   phase_d;
    logic [CNT_W-1:0] stable_q,  stable_d;
    logic [1:0]       attempt_q, attempt_d;
    logic [7:0]       lost_q,    lost_d;
    logic             lostPulse_q, lostPulse_d;
    logic             pllRst_q,  pllRst_d;
    logic [1:0]       domRst_q,  domRst_d;
    logic             lockOk_q,  lockOk_d;
    logic             fail_q,    fail_d;
    logic [1:0]       attemptInc;
    logic             lossOfLock;

    // pll_locked comes from the PLL's own timing, so it only passes through a plain two-flop synchroniser.
    always_ff @(posedge refclk_i) begin
        lockedMeta_q <= pll_locked_i;
        lockedSync_q <= lockedMeta_q;
    end

    assign attemptInc = (attempt_q == 2'd3) ? 2'd3 : attempt_q + 2'd1;
    assign lossOfLock = ((state_q == S_RELEASE) || (state_q == S_RUN)) && !lockedSync_q;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q + CNT_ONE;
        stable_d    = stable_q;
        attempt_d   = attempt_q;
        lost_d      = lost_q;
        lostPulse_d = 1'b0;

        if (restart_req_i) begin
            state_d   = S_RESET_PLL;
            phase_d   = '0;
            stable_d  = '0;
            attempt_d = 2'd0;
        end else if (lossOfLock) begin
            state_d     = S_RESET_PLL;
            phase_d     = '0;
            stable_d    = '0;
            attempt_d   = 2'd0;
            lostPulse_d = 1'b1;
            lost_d      = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    stable_d = '0;
                    if (phase_q == PULSE_LAST) begin
                        state_d = S_WAIT_LOCK;
                        phase_d = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    stable_d = lockedSync_q ? stable_q + CNT_ONE : '0;
                    // A completed stable run beats a timeout landing on the same cycle.
                    if (lockedSync_q && (stable_q == STABLE_LAST)) begin
                        state_d  = S_RELEASE;
                        phase_d  = '0;
                        stable_d = '0;
                    end else if (phase_q == TIMEOUT_LAST) begin
                        attempt_d = attemptInc;
                        phase_d   = '0;
                        stable_d  = '0;
                        state_d   = ((int'(attempt_q) + 1) >= MAX_ATTEMPTS) ? S_FAIL : S_RESET_PLL;
                    end
                end
                S_RELEASE: begin
                    if (phase_q == GAP_LAST) begin
                        state_d   = S_RUN;
                        phase_d   = '0;
                        attempt_d = 2'd0;
                    end
                end
                S_RUN: begin
                    phase_d   = '0;
                    attempt_d = 2'd0;
                end
                S_FAIL: begin
                    phase_d = '0;
                end
                default: begin
                    state_d  = S_RESET_PLL;
                    phase_d  = '0;
                    stable_d = '0;
                end
            endcase
        end
    end

    // Output registers are loaded from the next state so they switch together with it.
    always_comb begin
        pllRst_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
        lockOk_d = (state_d == S_RUN);
        fail_d   = (state_d == S_FAIL);
        case (state_d)
            S_RELEASE: domRst_d = 2'b10;
            S_RUN:     domRst_d = 2'b00;
            default:   domRst_d = 2'b11;
        endcase
    end

    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            state_q     <= S_RESET_PLL;
            phase_q     <= '0;
            stable_q    <= '0;
            attempt_q   <= 2'd0;
            lost_q      <= 8'd0;
            lostPulse_q <= 1'b0;
            pllRst_q    <= 1'b1;
            domRst_q    <= 2'b11;
            lockOk_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            stable_q    <= stable_d;
            attempt_q   <= attempt_d;
            lost_q      <= lost_d;
            lostPulse_q <= lostPulse_d;
            pllRst_q    <= pllRst_d;
            domRst_q    <= domRst_d;
            lockOk_q    <= lockOk_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_rst_o     = pllRst_q;
    assign dom_rst_o     = domRst_q;
    assign lock_ok_o     = lockOk_q;
    assign fail_o        = fail_q;
    assign lock_lost_o   = lostPulse_q;
    assign attempt_cnt_o = attempt_q;
    assign lost_cnt_o    = lost_q;

endmodule
